// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates ALU/LSU results onto the single register file
// write port and keeps a pending-write scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    output logic            issue_stall,

    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,

    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,

    output logic            rf_reg_write,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write_data,
    output logic [NREGS-1:0] busy_mask
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    src_e             last_grant;

    logic             issue_accept;
    logic             alu_grant;
    logic             lsu_grant;
    logic             xfer;
    logic [4:0]       xfer_rd;
    logic [XLEN-1:0]  xfer_data;

    // pending[0] is forced low, so x0 can never cause a stall.
    assign issue_stall  = issue_valid &
                          (pending[issue_rs1] | pending[issue_rs2] | pending[issue_rd]);
    assign issue_accept = issue_valid & ~issue_stall;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (alu_valid && lsu_valid) begin
            if (FIXED_PRIO != 0 || last_grant == SRC_LSU) begin
                alu_grant = 1'b1;
            end else begin
                lsu_grant = 1'b1;
            end
        end else begin
            alu_grant = alu_valid;
            lsu_grant = lsu_valid;
        end
    end

    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;
    assign xfer      = alu_grant | lsu_grant;
    assign xfer_rd   = alu_grant ? alu_rd   : lsu_rd;
    assign xfer_data = alu_grant ? alu_data : lsu_data;

    // Clear is applied before set, so a set to the same index wins.
    always_comb begin
        pending_next = pending;
        if (rf_reg_write) begin
            pending_next[rf_rd] = 1'b0;
        end
        if (issue_accept && issue_rd != 5'd0) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            last_grant    <= SRC_LSU;
            rf_reg_write  <= 1'b0;
            rf_rd         <= 5'd0;
            rf_write_data <= '0;
        end else begin
            pending      <= pending_next;
            rf_reg_write <= xfer && (xfer_rd != 5'd0);
            if (xfer) begin
                last_grant <= alu_grant ? SRC_ALU : SRC_LSU;
            end
            // A transfer to x0 is consumed without disturbing the write port.
            if (xfer && xfer_rd != 5'd0) begin
                rf_rd         <= xfer_rd;
                rf_write_data <= xfer_data;
            end
        end
    end

    assign busy_mask = pending;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: stimulus queues expected register file
// writes, negedge monitors pop and compare them; hazard/grant outputs are checked inline.
module tb_regfile_wb_scheduler;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        fp_alu_valid, fp_lsu_valid;
    logic        fp_issue_valid;

    logic        issue_stall, alu_ready, lsu_ready, rf_reg_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data, busy_mask;

    logic        fp_issue_stall, fp_alu_ready, fp_lsu_ready, fp_rf_reg_write;
    logic [4:0]  fp_rf_rd;
    logic [31:0] fp_rf_write_data, fp_busy_mask;

    wb_t exp_q[$];
    wb_t exp_fp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.XLEN(32), .NREGS(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
        .busy_mask(busy_mask)
    );

    regfile_wb_scheduler #(.XLEN(32), .NREGS(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(fp_issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_stall(fp_issue_stall),
        .alu_valid(fp_alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(fp_alu_ready),
        .lsu_valid(fp_lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(fp_lsu_ready),
        .rf_reg_write(fp_rf_reg_write), .rf_rd(fp_rf_rd), .rf_write_data(fp_rf_write_data),
        .busy_mask(fp_busy_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every committed write must match the head of its expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wb: got rd=%0d data=0x%0h expected no write", rf_rd, rf_write_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_rd", {27'd0, rf_rd}, {27'd0, e.rd});
                check("wb_data", rf_write_data, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && fp_rf_reg_write === 1'b1) begin
            if (exp_fp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fp_wb: got rd=%0d data=0x%0h expected no write", fp_rf_rd, fp_rf_write_data);
            end else begin
                wb_t e;
                e = exp_fp_q.pop_front();
                check("fp_wb_rd", {27'd0, fp_rf_rd}, {27'd0, e.rd});
                check("fp_wb_data", fp_rf_write_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        issue_valid    = 1'b0;
        issue_rs1      = 5'd0;
        issue_rs2      = 5'd0;
        issue_rd       = 5'd0;
        alu_valid      = 1'b0;
        lsu_valid      = 1'b0;
        alu_rd         = 5'd0;
        lsu_rd         = 5'd0;
        alu_data       = 32'd0;
        lsu_data       = 32'd0;
        fp_alu_valid   = 1'b0;
        fp_lsu_valid   = 1'b0;
        fp_issue_valid = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic [4:0]  rr_alu_rd  [3] = '{5'd1, 5'd3, 5'd6};
    logic [31:0] rr_alu_dat [3] = '{32'hA000_0001, 32'hA000_0003, 32'hA000_0006};
    logic [4:0]  rr_lsu_rd  [2] = '{5'd2, 5'd4};
    logic [31:0] rr_lsu_dat [2] = '{32'hB000_0002, 32'hB000_0004};
    logic        rr_exp_alu [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int ai;
        int li;
        set_idle();
        rst_n = 1'b0;
        #3;
        check("rst_issue_stall", {31'd0, issue_stall}, 32'd0);
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        check("rst_rf_reg_write", {31'd0, rf_reg_write}, 32'd0);
        check("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
        check("rst_rf_write_data", rf_write_data, 32'd0);
        check("rst_busy_mask", busy_mask, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // RAW on x5
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1 check("raw_first_issue_stall", {31'd0, issue_stall}, 32'd0);
        step();
        issue_rd = 5'd0; issue_rs1 = 5'd5;
        check("raw_busy_mask", busy_mask, 32'h0000_0020);
        #1 check("raw_stall", {31'd0, issue_stall}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1 check("raw_alu_ready", {31'd0, alu_ready}, 32'd1);
        exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
        step();
        alu_valid = 1'b0;
        check("raw_rf_write", {31'd0, rf_reg_write}, 32'd1);
        check("raw_stall_during_write", {31'd0, issue_stall}, 32'd1);
        step();
        check("raw_stall_dropped", {31'd0, issue_stall}, 32'd0);
        check("raw_busy_cleared", busy_mask, 32'd0);
        step();
        set_idle();

        // Round-robin contention from a fresh reset (ALU wins first)
        do_reset();
        ai = 0;
        li = 0;
        for (int c = 0; c < 5; c++) begin
            alu_valid = (ai < 3);
            alu_rd    = (ai < 3) ? rr_alu_rd[ai]  : 5'd0;
            alu_data  = (ai < 3) ? rr_alu_dat[ai] : 32'd0;
            lsu_valid = (li < 2);
            lsu_rd    = (li < 2) ? rr_lsu_rd[li]  : 5'd0;
            lsu_data  = (li < 2) ? rr_lsu_dat[li] : 32'd0;
            #1;
            check("rr_alu_ready", {31'd0, alu_ready}, {31'd0, rr_exp_alu[c]});
            check("rr_lsu_ready", {31'd0, lsu_ready}, {31'd0, ~rr_exp_alu[c]});
            if (rr_exp_alu[c]) begin
                exp_q.push_back('{rd: rr_alu_rd[ai], data: rr_alu_dat[ai]});
                ai++;
            end else begin
                exp_q.push_back('{rd: rr_lsu_rd[li], data: rr_lsu_dat[li]});
                li++;
            end
            step();
        end
        set_idle();
        step();
        step();
        check("rr_busy_mask_untouched", busy_mask, 32'd0);

        // Fixed priority instance: ALU holds the port while valid
        fp_alu_valid = 1'b1; fp_lsu_valid = 1'b1;
        lsu_rd = 5'd13; lsu_data = 32'hC000_000D;
        for (int c = 0; c < 3; c++) begin
            alu_rd   = 5'(10 + c);
            alu_data = 32'hC000_0000 + 32'(10 + c);
            #1;
            check("fp_alu_ready", {31'd0, fp_alu_ready}, 32'd1);
            check("fp_lsu_ready", {31'd0, fp_lsu_ready}, 32'd0);
            exp_fp_q.push_back('{rd: 5'(10 + c), data: 32'hC000_0000 + 32'(10 + c)});
            step();
        end
        fp_alu_valid = 1'b0;
        #1 check("fp_lsu_granted", {31'd0, fp_lsu_ready}, 32'd1);
        exp_fp_q.push_back('{rd: 5'd13, data: 32'hC000_000D});
        step();
        set_idle();
        step();

        // x0 never stalls and never writes
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1 check("x0_issue_rd0", {31'd0, issue_stall}, 32'd0);
        step();
        check("x0_busy_mask", busy_mask, 32'd0);
        issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        #1 check("x0_issue_rs0", {31'd0, issue_stall}, 32'd0);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234_5678;
        #1 check("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0;
        check("x0_no_rf_write", {31'd0, rf_reg_write}, 32'd0);
        step();

        // WAW on x7
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        check("waw_busy_mask", busy_mask, 32'h0000_0080);
        #1 check("waw_stall", {31'd0, issue_stall}, 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777_0001;
        #1 check("waw_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        exp_q.push_back('{rd: 5'd7, data: 32'h7777_0001});
        step();
        lsu_valid = 1'b0;
        check("waw_stall_during_write", {31'd0, issue_stall}, 32'd1);
        step();
        check("waw_stall_dropped", {31'd0, issue_stall}, 32'd0);
        step();
        issue_valid = 1'b0;
        check("waw_repend", busy_mask, 32'h0000_0080);
        lsu_valid = 1'b1; lsu_data = 32'h7777_0002;
        exp_q.push_back('{rd: 5'd7, data: 32'h7777_0002});
        step();
        lsu_valid = 1'b0;
        step();
        check("waw_busy_cleared", busy_mask, 32'd0);
        set_idle();

        // Asynchronous reset while a write is on the port
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd0; issue_rs1 = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_9999;
        step();
        check("mid_rf_write_before_rst", {31'd0, rf_reg_write}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rf_write", {31'd0, rf_reg_write}, 32'd0);
        check("mid_rst_busy_mask", busy_mask, 32'd0);
        check("mid_rst_stall", {31'd0, issue_stall}, 32'd0);
        set_idle();
        step();
        rst_n = 1'b1;
        step();
        step();

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("exp_fp_q_drained", exp_fp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
